// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg : shared UART frame constants and receiver state encoding
// Rev 1.0  : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS = 8;

  // Line levels shared with the transmit side.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [2:0] S_IDLE_ENC      = 3'd0;
  localparam logic [2:0] S_START_ENC     = 3'd1;
  localparam logic [2:0] S_DATA_ENC      = 3'd2;
  localparam logic [2:0] S_STOP_ENC      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH_ENC = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = S_IDLE_ENC,
    START     = S_START_ENC,
    DATA      = S_DATA_ENC,
    STOP      = S_STOP_ENC,
    WAIT_HIGH = S_WAIT_HIGH_ENC
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_bit_2ff.sv
// ----------------------------------------------------------------------------
// sync_bit_2ff : two-flop synchronizer for one asynchronous bit, resets to 1
// Rev 1.0      : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module sync_bit_2ff (
  input  logic clk_i,
  input  logic srst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx : oversampled UART receiver with valid/ready byte output,
//           framing-error and overrun pulses
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = uart_pkg::DATA_BITS
) (
  input  logic                 rx_sclk_i,
  input  logic                 rx_srst_i,
  input  logic                 rx_sdata_i,
  input  logic                 rx_pready_i,
  output logic [DATA_BITS-1:0] rx_pdata_o,
  output logic                 rx_pdata_valid_o,
  output logic                 rx_frame_err_o,
  output logic                 rx_overrun_o
);

  localparam int                CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        IDX_LAST = 3'(DATA_BITS - 1);

  logic                 s_line;
  rx_state_e            state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q,   shreg_d;
  logic                 deliver_q, deliver_d;
  logic                 ferr_q,    ferr_d;
  logic [DATA_BITS-1:0] pdata_q,   pdata_d;
  logic                 valid_q,   valid_d;
  logic                 ovr_q,     ovr_d;

  sync_bit_2ff u_sync (
    .clk_i  (rx_sclk_i),
    .srst_i (rx_srst_i),
    .d_i    (rx_sdata_i),
    .q_o    (s_line)
  );

  always_ff @(posedge rx_sclk_i) begin
    if (rx_srst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      deliver_q <= 1'b0;
      ferr_q    <= 1'b0;
      pdata_q   <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      deliver_q <= deliver_d;
      ferr_q    <= ferr_d;
      pdata_q   <= pdata_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    deliver_d = 1'b0;
    ferr_d    = 1'b0;
    pdata_d   = pdata_q;
    valid_d   = valid_q;
    ovr_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s_line == START_BIT) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_MID) begin
          if (s_line == START_BIT) begin
            state_d   = DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          shreg_d   = {s_line, shreg_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
            cnt_d   = '0;
          end
        end
      end
      STOP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // Returning to IDLE mid stop bit lets the next start edge follow directly.
          if (s_line == STOP_BIT) begin
            deliver_d = 1'b1;
            state_d   = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (s_line == STOP_BIT) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (valid_q && rx_pready_i) begin
      valid_d = 1'b0;
    end
    // A byte arriving in the same cycle the old one is taken replaces it cleanly.
    if (deliver_q) begin
      if (!valid_q || rx_pready_i) begin
        pdata_d = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_pdata_o       = pdata_q;
  assign rx_pdata_valid_o = valid_q;
  assign rx_frame_err_o   = ferr_q;
  assign rx_overrun_o     = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx : scenario tasks driving serial frames into uart_rx and checking
//              the parallel side against an event-level reference model
// Rev 1.0    : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

  localparam int OS      = 16;
  localparam int LATENCY = 2 + OS / 2 + 9 * OS + 1;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       line  = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] pdata;
  logic       valid;
  logic       ferr;
  logic       ovr;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .rx_sclk_i        (clk),
    .rx_srst_i        (rst),
    .rx_sdata_i       (line),
    .rx_pready_i      (ready),
    .rx_pdata_o       (pdata),
    .rx_pdata_valid_o (valid),
    .rx_frame_err_o   (ferr),
    .rx_overrun_o     (ovr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Observed parallel-side events
  logic [7:0] acc_q[$];
  int   err_cnt, ovr_cnt, rise_cnt, high_cnt, stab_viol, last_rise_cyc;
  int   fall_cyc;
  logic v_prev = 1'b0, acc_prev = 1'b0;
  logic [7:0] d_prev = 8'h00;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      v_prev   = 1'b0;
      acc_prev = 1'b0;
    end else begin
      if (valid && !v_prev) begin
        rise_cnt      = rise_cnt + 1;
        last_rise_cyc = cyc;
      end
      if (valid) high_cnt = high_cnt + 1;
      if (v_prev && !acc_prev && pdata !== d_prev) stab_viol = stab_viol + 1;
      if (valid && ready) acc_q.push_back(pdata);
      if (ferr === 1'b1) err_cnt = err_cnt + 1;
      if (ovr === 1'b1) ovr_cnt = ovr_cnt + 1;
      acc_prev = valid && ready;
      v_prev   = valid;
      d_prev   = pdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    acc_q.delete();
    err_cnt   = 0;
    ovr_cnt   = 0;
    rise_cnt  = 0;
    high_cnt  = 0;
    stab_viol = 0;
  endtask

  // Serial transmitter; the line is left at stop_lvl after the last stop period.
  task automatic send_frame(input logic [7:0] b, input int nstop, input logic stop_lvl);
    fall_cyc = cyc;
    line = 1'b0;
    repeat (OS) tick();
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (OS) tick();
    end
    line = stop_lvl;
    repeat (OS) tick();
    if (nstop > 1) begin
      line = 1'b1;
      repeat (OS * (nstop - 1)) tick();
    end
  endtask

  task automatic check_accepted(input string name, input logic [7:0] exp_q[$]);
    n_vec++;
    if (acc_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s count: got %0d bytes, expected %0d", name, acc_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (acc_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL %s byte%0d: got %h, expected %h", name, i, acc_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_outputs_reset(input string name);
    @(negedge clk);
    n_vec++;
    if ({pdata, valid, ferr, ovr} !== 11'h000) begin
      n_err++;
      $display("FAIL %s: got pdata=%h valid=%b ferr=%b ovr=%b, expected all zero",
               name, pdata, valid, ferr, ovr);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; line = 1'b1; ready = 1'b0;
    repeat (3) tick();
    check_outputs_reset("reset_values");
    tick();
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_single_a5;
    logic [7:0] exp_q[$];
    clear_mon();
    ready = 1'b1;
    send_frame(8'hA5, 1, 1'b1);
    repeat (8) tick();
    exp_q.push_back(8'hA5);
    check_accepted("a5_data", exp_q);
    check_int("a5_latency", last_rise_cyc - fall_cyc - 1, LATENCY);
    check_int("a5_valid_cycles", high_cnt, 1);
    check_int("a5_ferr", err_cnt, 0);
    check_int("a5_ovr", ovr_cnt, 0);
  endtask

  task automatic test_back_to_back_overrun;
    logic [7:0] exp_q[$];
    clear_mon();
    ready = 1'b0;
    send_frame(8'h00, 2, 1'b1);
    send_frame(8'hFF, 2, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    n_vec++;
    if (valid !== 1'b1 || pdata !== 8'h00) begin
      n_err++;
      $display("FAIL b2b_hold: got valid=%b pdata=%h, expected valid=1 pdata=00", valid, pdata);
    end
    check_int("b2b_overrun", ovr_cnt, 1);
    check_int("b2b_ferr", err_cnt, 0);
    check_int("b2b_stability", stab_viol, 0);
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    @(negedge clk);
    n_vec++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_clear: got valid=%b, expected 0", valid);
    end
    exp_q.push_back(8'h00);
    check_accepted("b2b_data", exp_q);
  endtask

  task automatic test_glitch;
    logic [7:0] exp_q[$];
    clear_mon();
    ready = 1'b1;
    line = 1'b0;
    repeat (3) tick();
    line = 1'b1;
    repeat (3 * OS) tick();
    check_int("glitch_no_valid", rise_cnt, 0);
    check_int("glitch_no_ferr", err_cnt, 0);
    send_frame(8'h3C, 1, 1'b1);
    repeat (8) tick();
    exp_q.push_back(8'h3C);
    check_accepted("glitch_then_3c", exp_q);
  endtask

  task automatic test_framing_error;
    logic [7:0] exp_q[$];
    clear_mon();
    ready = 1'b1;
    send_frame(8'h81, 1, 1'b0);
    repeat (40) tick();
    line = 1'b1;
    repeat (2 * OS) tick();
    check_int("ferr_pulses", err_cnt, 1);
    check_int("ferr_no_valid", rise_cnt, 0);
    check_int("ferr_no_ovr", ovr_cnt, 0);
    send_frame(8'h55, 1, 1'b1);
    repeat (8) tick();
    exp_q.push_back(8'h55);
    check_accepted("ferr_then_55", exp_q);
  endtask

  task automatic test_accept_on_delivery;
    logic [7:0] exp_q[$];
    clear_mon();
    ready = 1'b0;
    send_frame(8'h12, 1, 1'b1);
    repeat (4) tick();
    fork
      send_frame(8'h34, 1, 1'b1);
      begin
        repeat (LATENCY) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
      end
    join
    repeat (2) tick();
    @(negedge clk);
    n_vec++;
    if (valid !== 1'b1 || pdata !== 8'h34) begin
      n_err++;
      $display("FAIL swap_load: got valid=%b pdata=%h, expected valid=1 pdata=34", valid, pdata);
    end
    check_int("swap_no_ovr", ovr_cnt, 0);
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    check_accepted("swap_data", exp_q);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    clear_mon();
    ready = 1'b0;
    send_frame(8'h5A, 1, 1'b1);
    repeat (4) tick();
    b = 8'($urandom_range(0, 255));
    line = 1'b0;
    repeat (OS) tick();
    for (int i = 0; i < 4; i++) begin
      line = b[i];
      repeat (OS) tick();
    end
    line = b[4];
    repeat (OS / 2) tick();
    rst  = 1'b1;
    line = 1'b1;
    tick();
    rst = 1'b0;
    check_outputs_reset("midframe_reset");
    clear_mon();
    ready = 1'b1;
    repeat (12 * OS) tick();
    check_int("midframe_no_valid", rise_cnt, 0);
    check_int("midframe_no_ferr", err_cnt, 0);
    send_frame(8'hC3, 1, 1'b1);
    repeat (8) tick();
    exp_q.push_back(8'hC3);
    check_accepted("midframe_then_c3", exp_q);
  endtask

  task automatic test_random_stream;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    clear_mon();
    ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, int'($urandom_range(1, 2)), 1'b1);
      repeat ($urandom_range(0, 20)) tick();
    end
    repeat (8) tick();
    check_accepted("random_stream", exp_q);
    check_int("random_ferr", err_cnt, 0);
    check_int("random_ovr", ovr_cnt, 0);
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single_a5();
    test_back_to_back_overrun();
    test_glitch();
    test_framing_error();
    test_accept_on_delivery();
    test_reset_mid_frame();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial-to-parallel UART receiver. It is the downstream partner of the transmit stage on the same serial link.
- Frame: 1 start bit (0), 8 data bits LSB first, then stop bit(s) (1). The transmitter sends 2 stop bits; this block checks only the first.
- Samples the asynchronous line with an oversampled bit clock and presents each received byte on a valid/ready parallel interface.
- Flags framing errors and overruns.

Parameters:
OVERSAMPLE, 16, clock cycles per serial bit period; even, >= 4
DATA_BITS, 8, data bits per frame; fixed at 8 in this revision

Ports:
rx_sclk_i  input  1  receiver clock, OVERSAMPLE x bit rate; sole clock
rx_srst_i  input  1  synchronous, active-high reset
rx_sdata_i  input  1  serial line, asynchronous, idle high
rx_pready_i  input  1  consumer ready; byte accepted when rx_pdata_valid_o & rx_pready_i
rx_pdata_o  output  8  received byte (holding register)
rx_pdata_valid_o  output  1  holding register holds an unaccepted byte
rx_frame_err_o  output  1  one-cycle pulse: stop bit sampled 0
rx_overrun_o  output  1  one-cycle pulse: completed byte dropped because holding register was full

Behaviour:
- Clock and reset: one clock (rx_sclk_i). Reset is synchronous and active-high (rx_srst_i), sampled on the rising edge of rx_sclk_i.
- Reset values: rx_pdata_o=8'h00, rx_pdata_valid_o=0, rx_frame_err_o=0, rx_overrun_o=0, state=IDLE, counters=0, synchronizer flops=1.
- Reset mid-frame aborts the frame with no output. After reset release the FSM is in IDLE, and a line already low is treated as a start edge.
- Input synchronizer: rx_sdata_i passes through 2 flops; the result is s_line. All FSM decisions use s_line only.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. cnt is the oversample counter (width clog2(OVERSAMPLE)); bit_idx is 0..7.
- IDLE: s_line==0 -> START, cnt=0.
- START: cnt increments each cycle. At cnt==OVERSAMPLE/2-1 (mid start bit):
  - s_line==0 -> DATA, cnt=0, bit_idx=0.
  - s_line==1 -> IDLE (glitch rejected; no flags).
- DATA: cnt increments and wraps at OVERSAMPLE-1. On each cnt==OVERSAMPLE-1 cycle (mid-bit):
  - shift s_line into shift register MSB, shifting right (LSB-first reconstruction);
  - bit_idx++;
  - after the 8th sample (bit_idx==7 at sample) -> STOP, cnt=0.
- STOP: at cnt==OVERSAMPLE-1:
  - s_line==1 -> deliver the byte, -> IDLE.
  - s_line==0 -> rx_frame_err_o pulses 1 cycle, byte discarded, -> WAIT_HIGH.
- WAIT_HIGH: stay until s_line==1, then -> IDLE. This prevents a break condition from re-triggering reception.
- Delivery, registered in the cycle after the stop sample:
  - valid==0: load rx_pdata_o, set valid.
  - valid==1 and rx_pready_i==1 in the same cycle: load new byte, valid stays 1, no overrun.
  - valid==1 and rx_pready_i==0: keep the old byte, pulse rx_overrun_o for 1 cycle, drop the new byte.
- Handshake:
  - valid clears on the cycle after valid&ready, unless a new byte loads in that same cycle.
  - rx_pdata_o stays stable while valid==1 and not accepted.
  - Valid does not depend combinationally on ready.
- Latency, line falling edge to valid rise: 2 (sync) + OVERSAMPLE/2 + 9*OVERSAMPLE + 1 cycles. For OVERSAMPLE=16 this is 155 cycles.
- Back-to-back frames: IDLE is re-entered mid stop bit, so a start edge after the stop bit(s) is detected with no gap requirement beyond the stop sample.
- Counter arithmetic is modulo its width; no other wrap conditions exist.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams (IDLE..WAIT_HIGH);
  - DATA_BITS=8;
  - START_BIT=1'b0 and STOP_BIT=1'b1, shared with the transmit side.
- Sub-module sync_bit_2ff: 2-flop synchronizer, reset value 1, same clock and reset. Reusable for other async single-bit inputs.

Test Plan:
1. Reset, then send 0xA5 (OVERSAMPLE=16, 16 cycles/bit), rx_pready_i=1 -> rx_pdata_o=8'hA5, valid high for exactly 1 cycle, 155 cycles after the start edge; no error pulses.
2. Two back-to-back frames 0x00 then 0xFF with 2 stop bits, rx_pready_i held 0 until after both -> first byte 0x00 held, rx_overrun_o pulses once when 0xFF completes, rx_pdata_o stays 0x00.
3. Line low for 3 cycles then high (glitch) -> START rejects at mid-bit, FSM returns to IDLE, no valid, no flags; then 0x3C is received correctly.
4. Frame 0x81 with stop bit driven 0, line held low 40 further cycles, then high -> rx_frame_err_o pulses once, valid stays 0, no re-trigger during the low period; next frame 0x55 is received.
5. valid high with 0x12 and rx_pready_i asserted in the same cycle a new 0x34 completes -> rx_pdata_o=0x34, valid stays 1, no overrun.
6. rx_srst_i asserted for 1 cycle at data bit 4 of a frame -> all outputs at reset values next cycle, no valid for the partial frame; the following full frame 0xC3 is received correctly.
